deposit_pulser: RTL and testbench

Parametrised multi-channel deposit input controller for the ATM front panel. It accepts N raw push-button lines, one per denomination or deposit key. Each line is synchronised and debounced, and a confirmed press becomes a single-cycle `count_up` pulse tagged with the channel index. Holding a key auto-repeats. Downstream balance/counter logic consumes `count_up`/`count_ch` directly; `lock` suppresses deposits while a withdrawal or other transaction owns the balance.

---
 rtl/deposit_pulser.sv | 169 ++++++++++++++++
 tb/tb_deposit_pulser.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/deposit_pulser.sv
// rtl/deposit_pulser.sv - multi-channel debounced deposit key pulser with auto-repeat
// Each key: 2-flop sync, debounce FSM, repeat timer; a lowest-index arbiter serialises events.
module deposit_pulser #(
  parameter int N_CH          = 4,
  parameter int DEBOUNCE_CYC  = 4,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_PERIOD = 4,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] UP_Button,
  input  logic            lock,
  output logic            count_up,
  output logic [CH_W-1:0] count_ch,
  output logic [N_CH-1:0] held,
  output logic            overrun
);

  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DEB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int REP_W   = $clog2(REP_MAX + 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  state_t            state   [N_CH];
  logic [DEB_W-1:0]  deb_cnt [N_CH];
  logic [REP_W-1:0]  rep_cnt [N_CH];
  logic [N_CH-1:0]   sync1;
  logic [N_CH-1:0]   sync2;
  logic [N_CH-1:0]   pend;
  logic [N_CH-1:0]   evt;
  logic [N_CH-1:0]   grant_oh;
  logic              grant_vld;
  logic [CH_W-1:0]   grant_idx;

  // Press confirmation and repeat expiry, seen in the cycle before the FSM edge.
  always_comb begin
    evt = '0;
    for (int i = 0; i < N_CH; i++) begin
      case (state[i])
        IDLE:      evt[i] = sync2[i] && (DEBOUNCE_CYC == 1);
        DEB_PRESS: evt[i] = sync2[i] && (deb_cnt[i] == DEB_W'(DEBOUNCE_CYC - 1));
        HELD:      evt[i] = sync2[i] && (REPEAT_EN != 0) && (rep_cnt[i] == REP_W'(1));
        default:   evt[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      held  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        state[i]   <= IDLE;
        deb_cnt[i] <= '0;
        rep_cnt[i] <= '0;
      end
    end else begin
      sync1 <= UP_Button;
      sync2 <= sync1;
      for (int i = 0; i < N_CH; i++) begin
        case (state[i])
          IDLE: begin
            if (sync2[i]) begin
              if (DEBOUNCE_CYC == 1) begin
                state[i]   <= HELD;
                held[i]    <= 1'b1;
                rep_cnt[i] <= REP_W'(REPEAT_DELAY);
              end else begin
                state[i]   <= DEB_PRESS;
                deb_cnt[i] <= DEB_W'(1);
              end
            end
          end
          DEB_PRESS: begin
            if (!sync2[i]) begin
              state[i]   <= IDLE;
              deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_W'(DEBOUNCE_CYC - 1)) begin
              state[i]   <= HELD;
              held[i]    <= 1'b1;
              deb_cnt[i] <= '0;
              rep_cnt[i] <= REP_W'(REPEAT_DELAY);
            end else begin
              deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
            end
          end
          HELD: begin
            if (!sync2[i]) begin
              if (DEBOUNCE_CYC == 1) begin
                state[i] <= IDLE;
                held[i]  <= 1'b0;
              end else begin
                state[i]   <= DEB_RELEASE;
                deb_cnt[i] <= DEB_W'(1);
              end
            end else if (REPEAT_EN != 0) begin
              // Reload instead of decrementing through zero so the timer never wraps.
              if (rep_cnt[i] > REP_W'(1))
                rep_cnt[i] <= rep_cnt[i] - REP_W'(1);
              else
                rep_cnt[i] <= REP_W'(REPEAT_PERIOD);
            end
          end
          DEB_RELEASE: begin
            if (sync2[i]) begin
              state[i]   <= HELD;
              deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_W'(DEBOUNCE_CYC - 1)) begin
              state[i]   <= IDLE;
              held[i]    <= 1'b0;
              deb_cnt[i] <= '0;
            end else begin
              deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
            end
          end
          default: begin
            state[i] <= IDLE;
            held[i]  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Descending scan leaves the lowest pending index as the winner.
  always_comb begin
    grant_oh  = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pend[i] && !lock) begin
        grant_oh    = '0;
        grant_oh[i] = 1'b1;
        grant_vld   = 1'b1;
        grant_idx   = CH_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend     <= '0;
      count_up <= 1'b0;
      count_ch <= '0;
      overrun  <= 1'b0;
    end else begin
      count_up <= grant_vld;
      if (grant_vld)
        count_ch <= grant_idx;
      if (lock) begin
        pend    <= '0;
        overrun <= 1'b0;
      end else begin
        pend    <= (pend & ~grant_oh) | evt;
        overrun <= |(evt & pend & ~grant_oh);
      end
    end
  end

endmodule

// File: tb/tb_deposit_pulser.sv
// tb/tb_deposit_pulser.sv - directed and random check of deposit_pulser against a run-length model
module tb_deposit_pulser;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      UP_Button;
  logic            lock;
  logic [2:0]      cu;
  logic [2:0][1:0] cch;
  logic [2:0][3:0] hld;
  logic [2:0]      ovr;

  always #5 clk = ~clk;

  deposit_pulser dut_a (
    .clk(clk), .reset(reset), .UP_Button(UP_Button), .lock(lock),
    .count_up(cu[0]), .count_ch(cch[0]), .held(hld[0]), .overrun(ovr[0])
  );
  deposit_pulser #(.REPEAT_EN(0)) dut_b (
    .clk(clk), .reset(reset), .UP_Button(UP_Button), .lock(lock),
    .count_up(cu[1]), .count_ch(cch[1]), .held(hld[1]), .overrun(ovr[1])
  );
  deposit_pulser #(.DEBOUNCE_CYC(1), .REPEAT_DELAY(2), .REPEAT_PERIOD(1)) dut_c (
    .clk(clk), .reset(reset), .UP_Button(UP_Button), .lock(lock),
    .count_up(cu[2]), .count_ch(cch[2]), .held(hld[2]), .overrun(ovr[2])
  );

  int    p_deb [3] = '{4, 4, 1};
  int    p_ren [3] = '{1, 0, 1};
  int    p_dly [3] = '{16, 16, 2};
  int    p_per [3] = '{4, 4, 1};
  string dn    [3] = '{"A", "B", "C"};

  // model state: sampled key pipeline, run lengths, debounced level, repeat age
  logic bd1 [3][4], bd2 [3][4], mheld [3][4], prev_s [3][4], pend [3][4];
  int   hi_run [3][4], lo_run [3][4], age [3][4];
  logic m_up [3], m_ovr [3];
  int   m_ch [3];

  typedef struct { int d; int cyc; int ch; } pulse_t;
  pulse_t plog [$];
  int     ovr_cnt [3];
  int     fall_cyc [3][4];
  logic [3:0] prev_hld [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 4; i++) begin
        bd1[d][i] = 0; bd2[d][i] = 0; mheld[d][i] = 0; prev_s[d][i] = 0; pend[d][i] = 0;
        hi_run[d][i] = 0; lo_run[d][i] = 0; age[d][i] = 0;
      end
      m_up[d] = 0; m_ovr[d] = 0; m_ch[d] = 0;
    end
  endtask

  task automatic model_step();
    int   g;
    logic nov, s, ev;
    for (int d = 0; d < 3; d++) begin
      g = -1;
      nov = 0;
      if (!lock)
        for (int i = 3; i >= 0; i--) if (pend[d][i]) g = i;
      for (int i = 0; i < 4; i++) begin
        s = bd2[d][i];
        bd2[d][i] = bd1[d][i];
        bd1[d][i] = UP_Button[i];
        ev = 0;
        if (s) begin hi_run[d][i]++; lo_run[d][i] = 0; end
        else   begin lo_run[d][i]++; hi_run[d][i] = 0; end
        if (!mheld[d][i]) begin
          if (hi_run[d][i] == p_deb[d]) begin mheld[d][i] = 1; age[d][i] = 0; ev = 1; end
        end else if (!s) begin
          if (lo_run[d][i] == p_deb[d]) mheld[d][i] = 0;
        end else if (prev_s[d][i] && p_ren[d] != 0) begin
          age[d][i]++;
          if (age[d][i] == p_dly[d] ||
              (age[d][i] > p_dly[d] && (age[d][i] - p_dly[d]) % p_per[d] == 0))
            ev = 1;
        end
        prev_s[d][i] = s;
        if (lock) pend[d][i] = 0;
        else begin
          if (ev && pend[d][i] && g != i) nov = 1;
          if (ev) pend[d][i] = 1;
          else if (g == i) pend[d][i] = 0;
        end
      end
      m_up[d]  = (g >= 0);
      if (g >= 0) m_ch[d] = g;
      m_ovr[d] = nov;
    end
  endtask

  task automatic step();
    logic [3:0] hv;
    pulse_t     p;
    @(posedge clk);
    cyc++;
    if (reset) model_step();
    else       model_reset();
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 4; i++) hv[i] = mheld[d][i];
      check($sformatf("%s.count_up", dn[d]), cu[d], m_up[d]);
      check($sformatf("%s.count_ch", dn[d]), cch[d], m_ch[d]);
      check($sformatf("%s.held", dn[d]), hld[d], hv);
      check($sformatf("%s.overrun", dn[d]), ovr[d], m_ovr[d]);
      if (cu[d] === 1'b1) begin p.d = d; p.cyc = cyc; p.ch = cch[d]; plog.push_back(p); end
      if (ovr[d] === 1'b1) ovr_cnt[d]++;
      for (int i = 0; i < 4; i++)
        if (prev_hld[d][i] && !hld[d][i]) fall_cyc[d][i] = cyc;
      prev_hld[d] = hld[d];
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  function automatic int npulse(input int d, input int lo, input int hi);
    int n = 0;
    foreach (plog[j]) if (plog[j].d == d && plog[j].cyc >= lo && plog[j].cyc <= hi) n++;
    return n;
  endfunction

  function automatic int pulse_at(input int d, input int lo, input int k, output int ch);
    int n = 0;
    ch = -1;
    foreach (plog[j]) begin
      if (plog[j].d == d && plog[j].cyc >= lo) begin
        if (n == k) begin ch = plog[j].ch; return plog[j].cyc; end
        n++;
      end
    end
    return -1;
  endfunction

  int e0, r0, s0, t, ch, o0, cnt [4];

  initial begin
    reset = 1'b0; UP_Button = '0; lock = 1'b0;
    model_reset();
    for (int d = 0; d < 3; d++) begin
      ovr_cnt[d] = 0; prev_hld[d] = '0;
      for (int i = 0; i < 4; i++) fall_cyc[d][i] = -1;
    end
    run(3);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s.rst_count_up", dn[d]), cu[d], 0);
      check($sformatf("%s.rst_count_ch", dn[d]), cch[d], 0);
      check($sformatf("%s.rst_held", dn[d]), hld[d], 0);
      check($sformatf("%s.rst_overrun", dn[d]), ovr[d], 0);
    end
    reset = 1'b1;
    run(3);

    // single press on channel 2, non-repeating instance
    e0 = cyc + 1; UP_Button = 4'b0100; run(30);
    UP_Button = '0; r0 = cyc + 1; run(20);
    check("press_count", npulse(1, e0, cyc), 1);
    t = pulse_at(1, e0, 0, ch);
    check("press_latency", t, e0 + 6);
    check("press_ch", ch, 2);
    check("release_held_fall", fall_cyc[1][2], r0 + 5);

    // auto-repeat on channel 1, default instance
    e0 = cyc + 1; UP_Button = 4'b0010; run(40);
    UP_Button = '0; r0 = cyc + 1; run(30);
    check("rep0", pulse_at(0, e0, 0, ch), e0 + 6);
    check("rep1", pulse_at(0, e0, 1, ch), e0 + 22);
    check("rep2", pulse_at(0, e0, 2, ch), e0 + 26);
    check("rep3", pulse_at(0, e0, 3, ch), e0 + 30);
    check("rep_ch", ch, 1);
    check("rep_stop", npulse(0, r0 + 4, cyc), 0);

    // bounce on channel 0
    e0 = cyc + 1; UP_Button = 4'b0001; run(3);
    UP_Button = '0; run(1);
    UP_Button = 4'b0001; s0 = cyc + 1; run(15);
    UP_Button = '0; run(20);
    check("bounce_glitch", npulse(1, e0, s0 + 5), 0);
    check("bounce_press", pulse_at(1, e0, 0, ch), s0 + 6);

    // contention between channels 0 and 3
    o0 = ovr_cnt[1];
    e0 = cyc + 1; UP_Button = 4'b1001; run(15);
    UP_Button = '0; run(20);
    check("cont_first", pulse_at(1, e0, 0, ch), e0 + 6);
    check("cont_first_ch", ch, 0);
    check("cont_second", pulse_at(1, e0, 1, ch), e0 + 7);
    check("cont_second_ch", ch, 3);
    check("cont_overrun", ovr_cnt[1] - o0, 0);

    // lock suppresses a whole press
    o0 = ovr_cnt[1];
    lock = 1'b1;
    e0 = cyc + 1; UP_Button = 4'b0010; run(20);
    UP_Button = '0; run(12);
    lock = 1'b0; run(5);
    check("lock_pulses", npulse(1, e0, cyc), 0);
    check("lock_overrun", ovr_cnt[1] - o0, 0);
    e0 = cyc + 1; UP_Button = 4'b0010; run(12);
    UP_Button = '0; run(20);
    check("unlock_press", pulse_at(1, e0, 0, ch), e0 + 6);
    check("unlock_ch", ch, 1);

    // starve channel 1 on the fast-repeat instance, lock toggling
    o0 = ovr_cnt[2];
    UP_Button = 4'b0011;
    for (int k = 0; k < 8; k++) begin run(3); lock = ~lock; end
    lock = 1'b0; run(10);
    check("overrun_seen", (ovr_cnt[2] - o0) > 0, 1);

    // asynchronous reset while keys are held
    #2 reset = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s.arst_count_up", dn[d]), cu[d], 0);
      check($sformatf("%s.arst_held", dn[d]), hld[d], 0);
      check($sformatf("%s.arst_overrun", dn[d]), ovr[d], 0);
    end
    model_reset();
    run(2);
    reset = 1'b1;
    e0 = cyc + 1; run(12);
    check("rearm_press", pulse_at(1, e0, 0, ch), e0 + 6);
    check("rearm_ch", ch, 0);
    UP_Button = '0; run(20);

    // random keys with bounces and lock
    for (int i = 0; i < 4; i++) cnt[i] = $urandom_range(1, 20);
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 4; i++) begin
        cnt[i]--;
        if (cnt[i] <= 0) begin
          UP_Button[i] = ~UP_Button[i];
          cnt[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 50);
        end
      end
      if ($urandom_range(0, 99) < 3) lock = ~lock;
      run(1);
    end
    lock = 1'b0; UP_Button = '0; run(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
